// File: rtl/rf_wb_if.sv
// Writeback request / register-file write-port bundle shared by the ALU and LSU
// writeback paths and the rf_wb_arbiter.
interface rf_wb_if #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
);
  logic          r0_valid;
  logic          r0_ready;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_data;
  logic          r1_valid;
  logic          r1_ready;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_data;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic          WE3;
  logic [NREG-1:0] pend_mask;

  // Requesters and register-file side.
  modport master (
    output r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
    input  r0_ready, r1_ready, A3, WD3, WE3, pend_mask
  );

  // Arbiter side.
  modport slave (
    input  r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
    output r0_ready, r1_ready, A3, WD3, WE3, pend_mask
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Define RF_ARB_RR_EN for round-robin on different-address conflicts (default: LSU wins).
module rf_wb_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  rf_wb_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e      st0, st1, st0_nx, st1_nx;
  logic [AW-1:0]   addr0, addr1;
  logic [DW-1:0]   data0, data1;
  logic            r1_older, r1_older_nx;
  logic            elig0, elig1, pick1, gnt0, gnt1, acc0, acc1;
  logic [NREG-1:0] pend;
`ifdef RF_ARB_RR_EN
  logic            rr_ptr;
`endif

  // Register 0 is a sink: such entries are never eligible for a grant.
  assign elig0 = (st0 == FULL) && (addr0 != '0);
  assign elig1 = (st1 == FULL) && (addr1 != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick1 = elig1;
    if (elig0 && elig1) begin
      if (addr0 == addr1) begin
        pick1 = r1_older;
      end else begin
`ifdef RF_ARB_RR_EN
        // rr_ptr == 0 favours the LSU, matching the fixed-priority order out of reset.
        pick1 = ~rr_ptr;
`else
        pick1 = 1'b1;
`endif
      end
    end
  end

  assign gnt1 = elig1 & pick1;
  assign gnt0 = elig0 & ~pick1;

  assign bus.r0_ready = (st0 == EMPTY) | gnt0;
  assign bus.r1_ready = (st1 == EMPTY) | gnt1;
  assign acc0 = bus.r0_valid & bus.r0_ready;
  assign acc1 = bus.r1_valid & bus.r1_ready;

  always_comb begin
    st0_nx      = st0;
    st1_nx      = st1;
    r1_older_nx = r1_older;
    if (acc0)                                    st0_nx = FULL;
    else if ((st0 == FULL) && (gnt0 || !elig0))  st0_nx = EMPTY;
    if (acc1)                                    st1_nx = FULL;
    else if ((st1 == FULL) && (gnt1 || !elig1))  st1_nx = EMPTY;
    // The entry that survives an edge untouched is older than a newly accepted one;
    // simultaneous acceptance treats req0 as older.
    if (acc0 && acc1)                  r1_older_nx = 1'b0;
    else if (acc1 && st0_nx == FULL)   r1_older_nx = 1'b0;
    else if (acc0 && st1_nx == FULL)   r1_older_nx = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0      <= EMPTY;
      st1      <= EMPTY;
      r1_older <= 1'b0;
    end else begin
      st0      <= st0_nx;
      st1      <= st1_nx;
      r1_older <= r1_older_nx;
    end
  end

  // NOTE: payload registers are not reset; the buffer state gates every use of them.
  always_ff @(posedge clk) begin
    if (acc0) begin
      addr0 <= bus.r0_addr;
      data0 <= bus.r0_data;
    end
    if (acc1) begin
      addr1 <= bus.r1_addr;
      data1 <= bus.r1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.A3  <= '0;
      bus.WD3 <= '0;
      bus.WE3 <= 1'b0;
    end else begin
      bus.WE3 <= gnt0 | gnt1;
      if (gnt1) begin
        bus.A3  <= addr1;
        bus.WD3 <= data1;
      end else if (gnt0) begin
        bus.A3  <= addr0;
        bus.WD3 <= data0;
      end
    end
  end

`ifdef RF_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_ptr <= 1'b0;
    else if (elig0 && elig1) rr_ptr <= ~rr_ptr;
  end
`endif

  always_comb begin
    pend = '0;
    if (elig0) pend[addr0] = 1'b1;
    if (elig1) pend[addr1] = 1'b1;
  end

  assign bus.pend_mask = pend;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter, compared cycle by cycle against
// a sequence-numbered reference model of the two writeback buffers.
module tb_rf_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rf_wb_if #(.AW(AW), .DW(DW), .NREG(NREG)) bus ();

  rf_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each buffer entry carries a global acceptance number, so
  // "older" is simply the smaller number.
  typedef struct {
    bit            full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   seq;
  } ent_t;

  ent_t          ent [2];
  int unsigned   seq_ctr;
  logic          exp_we;
  logic [AW-1:0] exp_a3;
  logic [DW-1:0] exp_wd3;
  logic [DW-1:0] model_rf [NREG];
  logic [DW-1:0] seen_rf  [NREG];
  int            model_writes = 0;
  int            seen_writes  = 0;

  task automatic model_reset();
    for (int n = 0; n < 2; n++) ent[n] = '{full: 1'b0, addr: '0, data: '0, seq: 0};
    seq_ctr = 0;
    exp_we  = 1'b0;
    exp_a3  = '0;
    exp_wd3 = '0;
  endtask

  // Returns the requester granted this cycle, or -1.
  function automatic int winner();
    bit e0 = ent[0].full && (ent[0].addr != 0);
    bit e1 = ent[1].full && (ent[1].addr != 0);
    if (e0 && e1) begin
      if (ent[0].addr == ent[1].addr) return (ent[0].seq < ent[1].seq) ? 0 : 1;
      return 1;
    end
    if (e1) return 1;
    if (e0) return 0;
    return -1;
  endfunction

  task automatic check_outputs();
    int w = winner();
    logic [NREG-1:0] exp_pend = '0;
    for (int n = 0; n < 2; n++)
      if (ent[n].full && ent[n].addr != 0) exp_pend[ent[n].addr] = 1'b1;
    check("r0_ready", bus.r0_ready, !ent[0].full || w == 0);
    check("r1_ready", bus.r1_ready, !ent[1].full || w == 1);
    check("pend_mask", bus.pend_mask, exp_pend);
    check("WE3", bus.WE3, exp_we);
    check("A3", bus.A3, exp_a3);
    check("WD3", bus.WD3, exp_wd3);
    if (bus.WE3 === 1'b1) begin
      seen_rf[bus.A3] = bus.WD3;
      seen_writes++;
    end
  endtask

  task automatic model_edge(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int w = winner();
    bit acc [2];
    acc[0] = v0 && (!ent[0].full || w == 0);
    acc[1] = v1 && (!ent[1].full || w == 1);
    exp_we = (w >= 0);
    if (w >= 0) begin
      exp_a3  = ent[w].addr;
      exp_wd3 = ent[w].data;
      model_rf[ent[w].addr] = ent[w].data;
      model_writes++;
    end
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        ent[n].full = 1'b1;
        ent[n].addr = (n == 0) ? a0 : a1;
        ent[n].data = (n == 0) ? d0 : d1;
        ent[n].seq  = seq_ctr++;
      end else if (ent[n].full && (w == n || ent[n].addr == 0)) begin
        ent[n].full = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance model, step past the rising edge.
  task automatic cycle(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.r0_valid = v0; bus.r0_addr = a0; bus.r0_data = d0;
    bus.r1_valid = v1; bus.r1_addr = a1; bus.r1_data = d1;
    @(negedge clk);
    check_outputs();
    model_edge(v0, a0, d0, v1, a1, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      model_rf[r] = '0;
      seen_rf[r]  = '0;
    end
    bus.r0_valid = 0; bus.r0_addr = '0; bus.r0_data = '0;
    bus.r1_valid = 0; bus.r1_addr = '0; bus.r1_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, then single ALU write to x5.
    idle(1);
    cycle(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0);
    idle(3);

    // Same-edge writes to different registers: LSU first.
    cycle(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    idle(3);

    // Same-edge writes to the same register: ALU first, LSU value is final.
    cycle(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    idle(3);

    // Writes to x0 are swallowed.
    cycle(0, '0, '0, 1, 5'd0, 32'hFFFF_FFFF);
    idle(2);

    // Back-to-back saturation to distinct registers.
    for (int i = 0; i < 8; i++)
      cycle(1, 5'(8 + i), 32'hA000 + i, 1, 5'(16 + i), 32'hB000 + i);
    idle(4);

    // Random traffic over a narrow address range to provoke conflicts.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    idle(4);

    // Register file contents and write counts after all traffic so far.
    check("write_count", seen_writes, model_writes);
    for (int r = 0; r < NREG; r++) check($sformatf("rf_x%0d", r), seen_rf[r], model_rf[r]);

    // Reset while both buffers are full and a write is being issued.
    cycle(1, 5'd10, 32'hC0DE_0001, 1, 5'd11, 32'hC0DE_0002);
    cycle(1, 5'd10, 32'hC0DE_0003, 1, 5'd12, 32'hC0DE_0004);
    bus.r0_valid = 0;
    bus.r1_valid = 0;
    rst_n = 1'b0;
    #1;
    check("rst_WE3", bus.WE3, 1'b0);
    check("rst_pend_mask", bus.pend_mask, '0);
    check("rst_A3", bus.A3, '0);
    check("rst_WD3", bus.WD3, '0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
